// File: rtl/pe_mac_acc.sv
// Systolic MAC processing element: accumulates DEPTH operand products per result,
// forwards operands east/south. Define PE_SIGNED_EN for two's complement operands.
module pe_mac_acc #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3,
    localparam int ACC_W = 2*WIDTH + $clog2(DEPTH) + 1,
    localparam int CNT_W = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             fwd_valid,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] result,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef enum logic {ACC, HOLD} state_t;

    state_t state;
    state_t state_d;

    logic               accept;
    logic               last;
    logic [2*WIDTH-1:0] a_x;
    logic [2*WIDTH-1:0] b_x;
    logic [2*WIDTH-1:0] prod;
    logic               fill;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   sum;

    // Operands are widened to 2*WIDTH first so the low half of the product is exact.
`ifdef PE_SIGNED_EN
    assign a_x  = {{WIDTH{a_in[WIDTH-1]}}, a_in};
    assign b_x  = {{WIDTH{b_in[WIDTH-1]}}, b_in};
    assign fill = prod[2*WIDTH-1];
`else
    assign a_x  = {{WIDTH{1'b0}}, a_in};
    assign b_x  = {{WIDTH{1'b0}}, b_in};
    assign fill = 1'b0;
`endif

    assign prod     = a_x * b_x;
    assign prod_ext = {{(ACC_W-2*WIDTH){fill}}, prod};
    assign sum      = acc + prod_ext;
    assign last     = (beat_cnt == CNT_W'(DEPTH-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        in_ready = (state == ACC) && !clear;
        accept   = in_valid && in_ready;
        if (clear) begin
            state_d = ACC;
        end else begin
            unique case (state)
                ACC: begin
                    if (accept && last) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (res_valid && res_ready) begin
                        state_d = ACC;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            beat_cnt  <= '0;
            result    <= '0;
            res_valid <= 1'b0;
            fwd_valid <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
        end else if (clear) begin
            acc       <= '0;
            beat_cnt  <= '0;
            result    <= '0;
            res_valid <= 1'b0;
            fwd_valid <= 1'b0;
        end else begin
            fwd_valid <= accept;
            if (state == HOLD && res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            if (accept) begin
                a_out <= a_in;
                b_out <= b_in;
                if (last) begin
                    result    <= sum;
                    res_valid <= 1'b1;
                    acc       <= '0;
                    beat_cnt  <= '0;
                end else begin
                    acc      <= sum;
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_mac_acc.sv
// Bench for pe_mac_acc: directed scenarios plus randomized traffic
// checked every cycle against a queue-based dot-product model.
module tb_pe_mac_acc;

    localparam int W     = 4;
    localparam int D     = 3;
    localparam int ACC_W = 2*W + $clog2(D) + 1;
    localparam int CW    = $clog2(D+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic [W-1:0]  a_out;
    logic [W-1:0]  b_out;
    logic          fwd_valid;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [ACC_W-1:0] result;
    logic [CW-1:0] beat_cnt;

    int total = 0;
    int bad = 0;

    pe_mac_acc #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in),
        .a_out(a_out), .b_out(b_out), .fwd_valid(fwd_valid),
        .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    function automatic longint prod(logic [W-1:0] a, logic [W-1:0] b);
`ifdef PE_SIGNED_EN
        return longint'($signed(a)) * longint'($signed(b));
`else
        return longint'(a) * longint'(b);
`endif
    endfunction

    function automatic longint mask(longint v);
        logic [ACC_W-1:0] t;
        t = v[ACC_W-1:0];
        return longint'(t);
    endfunction

    task automatic check(string name, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: products of accepted beats wait in a queue until DEPTH of them form a result.
    longint       q[$];
    bit           m_rv;
    longint       m_res;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    bit           m_fwd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_rv = 0; m_res = 0; m_a = '0; m_b = '0; m_fwd = 0;
        end else if (clear) begin
            q.delete();
            m_rv = 0; m_res = 0; m_fwd = 0;
        end else begin
            bit take;
            take  = in_valid && !m_rv;
            m_fwd = take;
            if (m_rv && res_ready) m_rv = 0;
            if (take) begin
                m_a = a_in;
                m_b = b_in;
                q.push_back(prod(a_in, b_in));
                if (q.size() == D) begin
                    m_res = 0;
                    foreach (q[i]) m_res += q[i];
                    m_rv = 1;
                    q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", in_ready, (!m_rv && !clear));
            check("res_valid", res_valid, m_rv);
            check("fwd_valid", fwd_valid, m_fwd);
            check("a_out", a_out, m_a);
            check("b_out", b_out, m_b);
            check("beat_cnt", beat_cnt, q.size());
            if (m_rv) check("result", result, mask(m_res));
        end
    end

    task automatic step(bit v, logic [W-1:0] a, logic [W-1:0] b, bit rr, bit clr);
        in_valid  = v;
        a_in      = a;
        b_in      = b;
        res_ready = rr;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_a_out", a_out, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_result", result, 0);
        check("rst_fwd", fwd_valid, 0);
        check("rst_cnt", beat_cnt, 0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1);

`ifndef PE_SIGNED_EN
        step(1, 1, 4, 1, 0);
        check("t1_a_out", a_out, 1);
        check("t1_b_out", b_out, 4);
        check("t1_fwd", fwd_valid, 1);
        step(1, 2, 5, 1, 0);
        step(1, 3, 6, 1, 0);
        check("t1_rv", res_valid, 1);
        check("t1_result", result, 32);
        step(0, 0, 0, 1, 0);
        check("t1_drain", res_valid, 0);
        check("t1_fwd_lo", fwd_valid, 0);
        check("t1_a_hold", a_out, 3);

        repeat (3) step(1, 15, 15, 0, 0);
        check("t2_result", result, 675);
        repeat (5) begin
            step(1, 1, 1, 0, 0);
            check("t2_in_ready", in_ready, 0);
            check("t2_hold", result, 675);
        end
        step(1, 1, 1, 1, 0);
        check("t2_hs_rv", res_valid, 0);
        check("t2_hs_cnt", beat_cnt, 0);
        step(1, 1, 1, 1, 0);
        check("t2_next_cnt", beat_cnt, 1);
        repeat (2) step(1, 1, 1, 0, 0);
        check("t2_result2", result, 3);
        step(0, 0, 0, 1, 0);

        begin
            int vs[5] = '{1, 0, 1, 0, 1};
            int cs[5] = '{1, 1, 2, 2, 0};
            for (int i = 0; i < 5; i++) begin
                step(vs[i] != 0, 2, 3, 0, 0);
                check("t3_cnt", beat_cnt, cs[i]);
            end
        end
        check("t3_result", result, 18);
        step(0, 0, 0, 1, 0);
`else
        repeat (3) step(1, 4'hF, 4'h2, 0, 0);
        check("s1_result", result, mask(-6));
        step(0, 0, 0, 1, 0);
        repeat (3) step(1, 4'h8, 4'h8, 0, 0);
        check("s2_result", result, 192);
        step(0, 0, 0, 1, 0);
`endif

        repeat (2) step(1, 7, 7, 0, 0);
        check("t4_cnt2", beat_cnt, 2);
        step(1, 7, 7, 0, 1);
        check("t4_clr_cnt", beat_cnt, 0);
        check("t4_clr_rv", res_valid, 0);
        repeat (3) step(1, 1, 1, 0, 0);
        check("t4_result", result, 3);
        step(0, 0, 0, 1, 0);

        step(1, 1, 1, 0, 0);
        check("t5_cnt", beat_cnt, 1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t5_a_out", a_out, 0);
        check("t5_b_out", b_out, 0);
        check("t5_cnt0", beat_cnt, 0);
        check("t5_fwd", fwd_valid, 0);
        check("t5_rv", res_valid, 0);
        check("t5_result", result, 0);
        #3 rst = 1'b0;
        #1;
        check("t5_in_ready", in_ready, 1);
        repeat (3) step(1, 1, 1, 0, 0);
        check("t5_result3", result, 3);
        step(0, 0, 0, 1, 0);

        repeat (800) begin
            step($urandom_range(0, 3) != 0,
                 W'($urandom), W'($urandom),
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 39) == 0);
        end
        step(0, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
